alu_nibble_seq: RTL

Multi-nibble sequencer for the 4-bit ALU. It accepts one wide operation, N nibbles per operand, and issues it to the ALU one nibble per clock, least significant nibble first. Each nibble's carry/borrow is chained into the next nibble's Cin. The per-nibble results and flags are assembled into a wide result and one NZVC word. It sits between the control unit and the ALU, so wide-word arithmetic runs on the existing nibble datapath.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_nibble_seq_if.sv | 28 ++
 rtl/alu_seq_flagacc.sv | 49 ++++
 rtl/alu_nibble_seq.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the nibble ALU and its
// multi-nibble sequencer.
package alu_pkg;

  localparam logic [3:0] DADD   = 4'd0;
  localparam logic [3:0] DSUB   = 4'd1;
  localparam logic [3:0] LAND   = 4'd2;
  localparam logic [3:0] LOR    = 4'd3;
  localparam logic [3:0] LXOR   = 4'd4;
  localparam logic [3:0] INCA   = 4'd5;
  localparam logic [3:0] BFLAGS = 4'd6;
  localparam logic [3:0] PASSB  = 4'd7;
  localparam logic [3:0] ADD    = 4'd8;
  localparam logic [3:0] SUB    = 4'd9;
  localparam logic [3:0] ADC    = 4'd10;
  localparam logic [3:0] SBC    = 4'd11;
  localparam logic [3:0] MULLO  = 4'd12;
  localparam logic [3:0] MULHI  = 4'd13;
  localparam logic [3:0] DIV    = 4'd14;
  localparam logic [3:0] MOD    = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } seq_state_t;

  // Ops 12..15 need multi-cycle units the
  // nibble path does not have.
  function automatic logic op_unsupported(
    input logic [3:0] op
  );
    return op[3] & op[2];
  endfunction

endpackage

// File: rtl/alu_nibble_seq_if.sv
// Request/response bundle between the control
// unit and the multi-nibble sequencer.
interface alu_nibble_seq_if #(
  parameter int NIBBLES = 4
);

  logic                   start;
  logic [3:0]             op;
  logic [4*NIBBLES-1:0]   a;
  logic [4*NIBBLES-1:0]   b;
  logic                   cin;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [4*NIBBLES-1:0]   result;
  logic [3:0]             flags;

  modport master (
    output start, op, a, b, cin,
    input  busy, done, err, result, flags
  );

  modport slave (
    input  start, op, a, b, cin,
    output busy, done, err, result, flags
  );

endinterface

// File: rtl/alu_seq_flagacc.sv
// Carry chain, running zero accumulator and
// final NZVC assembly for the sequencer.
module alu_seq_flagacc
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       step,
  input  logic       last,
  input  logic       bflags,
  input  logic [3:0] bval,
  input  logic [3:0] alu_flags,
  output logic       carry,
  output logic [3:0] flags
);

  logic zacc;
  logic znext;

  assign znext = zacc & alu_flags[FLAG_Z];

  // Chain carry, fold Z, latch NZVC on the top nibble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      carry <= 1'b0;
      zacc  <= 1'b0;
      flags <= '0;
    end else if (clear) begin
      carry <= 1'b0;
      zacc  <= 1'b1;
      flags <= '0;
    end else if (step) begin
      carry <= alu_flags[FLAG_C];
      zacc  <= znext;
      if (last) begin
        if (bflags) begin
          flags <= bval;
        end else begin
          flags[FLAG_N] <= alu_flags[FLAG_N];
          flags[FLAG_Z] <= znext;
          flags[FLAG_V] <= alu_flags[FLAG_V];
          flags[FLAG_C] <= alu_flags[FLAG_C];
        end
      end
    end
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// Issues one wide op to the 4-bit ALU a nibble
// per clock, LSB first, chaining the carry.
module alu_nibble_seq
  import alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  alu_nibble_seq_if.slave bus,
  output logic [3:0] alu_A,
  output logic [3:0] alu_B,
  output logic [2:0] alu_op,
  output logic       alu_bank,
  output logic       alu_cin,
  input  logic [3:0] alu_result,
  input  logic [3:0] alu_flags
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
  localparam int W = 4 * NIBBLES;

  seq_state_t    state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_l;
  logic [W-1:0]  b_l;
  logic [3:0]    op_l;
  logic          cin_l;
  logic          busy_r;
  logic          done_r;
  logic          err_r;
  logic [W-1:0]  result_r;
  logic [3:0]    flags_w;
  logic          carry;
  logic          run;
  logic          last;
  logic          accept;
  logic          is_inca;

  assign run     = (state == S_RUN);
  assign last    = run && (idx == LAST);
  assign accept  = (state == S_IDLE) && bus.start;
  assign is_inca = (op_l == INCA);

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.err    = err_r;
  assign bus.result = result_r;
  assign bus.flags  = flags_w;

  // Nibble operands and op to the ALU; idle drives zero.
  always_comb begin
    alu_A    = '0;
    alu_B    = '0;
    alu_op   = '0;
    alu_bank = 1'b0;
    alu_cin  = 1'b0;
    if (run) begin
      alu_A = a_l[4*idx +: 4];
      if (is_inca) begin
        {alu_bank, alu_op} = ADD;
      end else begin
        alu_B = b_l[4*idx +: 4];
        {alu_bank, alu_op} = op_l;
      end
      if (idx == '0) begin
        alu_cin = is_inca ? 1'b1 : cin_l;
      end else begin
        alu_cin = carry;
      end
    end
  end

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      a_l      <= '0;
      b_l      <= '0;
      op_l     <= '0;
      cin_l    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      result_r <= '0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_l      <= bus.a;
            b_l      <= bus.b;
            op_l     <= bus.op;
            cin_l    <= bus.cin;
            idx      <= '0;
            result_r <= '0;
            if (op_unsupported(bus.op)) begin
              err_r  <= 1'b1;
              done_r <= 1'b1;
              state  <= S_FIN;
            end else begin
              err_r  <= 1'b0;
              busy_r <= 1'b1;
              state  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (op_l != BFLAGS) begin
            result_r[4*idx +: 4] <= alu_result;
          end
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= S_FIN;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  alu_seq_flagacc u_flagacc (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (accept),
    .step      (run),
    .last      (last),
    .bflags    (op_l == BFLAGS),
    .bval      (b_l[3:0]),
    .alu_flags (alu_flags),
    .carry     (carry),
    .flags     (flags_w)
  );

endmodule
